// File: rtl/crossing_fsm_pkg.sv
// crossing_fsm_pkg
//   Shared definitions for the zebra-crossing stop decision stage:
//   state encoding (also driven out on state_o for LEDs/debug) and
//   default parameter values for crossing_stop_fsm.
package crossing_fsm_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CONFIRM = 3'd1,
    STOP    = 3'd2,
    RELEASE = 3'd3,
    FAULT   = 3'd4
  } crossing_state_t;

  localparam int DEF_CONFIRM_FRAMES  = 3;
  localparam int DEF_RELEASE_FRAMES  = 5;
  localparam int DEF_MIN_BLOBS       = 4;
  localparam int DEF_HOLD_CYCLES     = 25_000_000; // 1 s at 25 MHz
  localparam int DEF_WATCHDOG_CYCLES = 1_680_000;  // 4 frames of 800x525

endpackage

// File: rtl/crossing_stop_fsm_sat_counter.sv
// sat_counter
//   Saturating up/down counter used for the hold timer, the verdict
//   watchdog and the confirm/release frame counters. Never wraps.
//   Priority: clear > load (to MAX) > inc > dec.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (count -> 0)
//   clear_i      force count to 0
//   load_i       force count to MAX
//   inc_i        +1, saturating at MAX
//   dec_i        -1, saturating at 0
//   count_o      current count
//   at_limit_o   count at MAX (DOWN=0) or at 0 (DOWN=1)
module sat_counter
  import crossing_fsm_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MAX   = 255,
  parameter bit DOWN  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] count_o,
  output logic             at_limit_o
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i)                        count_d = '0;
    else if (load_i)                    count_d = MAX_V;
    else if (inc_i && count_q != MAX_V) count_d = count_q + WIDTH'(1);
    else if (dec_i && count_q != '0)    count_d = count_q - WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o    = count_q;
  assign at_limit_o = DOWN ? (count_q == '0) : (count_q == MAX_V);

endmodule

// File: rtl/crossing_stop_fsm.sv
// crossing_stop_fsm
//   Debounced, hysteretic zebra-crossing stop command built from the
//   per-frame verdict of pattern_recognition, with a fail-safe FAULT
//   state when verdicts stop arriving. clk_video domain.
//
//   state   | meaning
//   IDLE    | no crossing, waiting for a hit frame
//   CONFIRM | counting consecutive hit frames toward CONFIRM_FRAMES
//   STOP    | stop asserted; hold timer running, reloaded on each hit
//   RELEASE | stop asserted; counting consecutive misses toward release
//   FAULT   | no verdict within WATCHDOG_CYCLES; stop+fault held
//
// Ports:
//   clk, rst_n           video clock, asynchronous active-low reset
//   detection_valid      one-cycle pulse per frame
//   crossing_detected    frame verdict, sampled with detection_valid
//   blob_count[7:0]      stripe count, sampled with detection_valid
//   zebra_crossing_stop  registered stop command
//   stop_event           one-cycle pulse on entry to STOP from IDLE/CONFIRM
//   fault                high while in FAULT
//   state_o[2:0]         current state encoding
//   frames_seen[15:0]    (CROSSING_STATS_EN) saturating verdict count
//   stop_count[15:0]     (CROSSING_STATS_EN) saturating stop_event count
// Build option: define CROSSING_STATS_EN to add the statistics outputs.
module crossing_stop_fsm
  import crossing_fsm_pkg::*;
#(
  parameter int CONFIRM_FRAMES  = DEF_CONFIRM_FRAMES,
  parameter int RELEASE_FRAMES  = DEF_RELEASE_FRAMES,
  parameter int MIN_BLOBS       = DEF_MIN_BLOBS,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int WATCHDOG_CYCLES = DEF_WATCHDOG_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       detection_valid,
  input  logic       crossing_detected,
  input  logic [7:0] blob_count,
  output logic       zebra_crossing_stop,
  output logic       stop_event,
  output logic       fault,
  output logic [2:0] state_o
`ifdef CROSSING_STATS_EN
  ,
  output logic [15:0] frames_seen,
  output logic [15:0] stop_count
`endif
);

  localparam int CW = $clog2(CONFIRM_FRAMES + 1);
  localparam int RW = $clog2(RELEASE_FRAMES + 1);
  localparam int TW = $clog2(HOLD_CYCLES + 1);
  localparam int WW = $clog2(WATCHDOG_CYCLES + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(CONFIRM_FRAMES - 1);
  localparam logic [RW-1:0] RCNT_LAST = RW'(RELEASE_FRAMES - 1);
  localparam logic [WW-1:0] WD_LAST   = WW'(WATCHDOG_CYCLES - 1);
  localparam logic [7:0]    MIN_B     = 8'(MIN_BLOBS);

  crossing_state_t state_q, state_d;

  logic hit, miss;
  logic stop_q, stop_d, event_q, event_d, fault_q, fault_d;

  logic [CW-1:0] cnt;
  logic [RW-1:0] rcnt;
  logic [TW-1:0] timer;
  logic [WW-1:0] wd;
  logic          cnt_at_limit, rcnt_at_limit, timer_zero, wd_at_limit;
  logic          hold_expired, wd_expired;
  logic          unused_limits;

  assign hit  = detection_valid && crossing_detected && (blob_count >= MIN_B);
  assign miss = detection_valid && !hit;

  // A miss in the cycle the timer steps 1 -> 0 already counts as expired.
  assign hold_expired = timer_zero || (timer == TW'(1));
  // Fault on the clock that brings the watchdog to its limit; a frame
  // pulse in that same cycle takes precedence.
  assign wd_expired   = !detection_valid && (wd_at_limit || wd == WD_LAST);

  // frame counters only ever stop one short of their limit
  assign unused_limits = cnt_at_limit ^ rcnt_at_limit;

  always_comb begin
    state_d = state_q;
    if (detection_valid) begin
      case (state_q)
        IDLE:
          if (hit) state_d = (CONFIRM_FRAMES == 1) ? STOP : CONFIRM;
        CONFIRM:
          if (hit && cnt == CNT_LAST) state_d = STOP;
          else if (miss)              state_d = IDLE;
        STOP:
          if (miss && hold_expired) state_d = (RELEASE_FRAMES == 1) ? IDLE : RELEASE;
        RELEASE:
          if (hit)                            state_d = STOP;
          else if (miss && rcnt == RCNT_LAST) state_d = IDLE;
        FAULT:
          state_d = IDLE;
        default:
          state_d = IDLE;
      endcase
    end else if (wd_expired) begin
      state_d = FAULT;
    end
  end

  always_comb begin
    stop_d  = (state_d == STOP) || (state_d == RELEASE) || (state_d == FAULT);
    fault_d = (state_d == FAULT);
    event_d = (state_d == STOP) && ((state_q == IDLE) || (state_q == CONFIRM));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      stop_q  <= 1'b0;
      event_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stop_q  <= stop_d;
      event_q <= event_d;
      fault_q <= fault_d;
    end
  end

  sat_counter #(.WIDTH(CW), .MAX(CONFIRM_FRAMES), .DOWN(1'b0)) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (state_d != CONFIRM),
    .load_i    (1'b0),
    .inc_i     (hit && state_d == CONFIRM),
    .dec_i     (1'b0),
    .count_o   (cnt),
    .at_limit_o(cnt_at_limit)
  );

  sat_counter #(.WIDTH(RW), .MAX(RELEASE_FRAMES), .DOWN(1'b0)) u_rcnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (state_d != RELEASE),
    .load_i    (1'b0),
    .inc_i     (miss && state_d == RELEASE),
    .dec_i     (1'b0),
    .count_o   (rcnt),
    .at_limit_o(rcnt_at_limit)
  );

  sat_counter #(.WIDTH(TW), .MAX(HOLD_CYCLES), .DOWN(1'b1)) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (!(state_d == STOP || state_d == RELEASE)),
    .load_i    (state_d == STOP && (state_q != STOP || hit)),
    .inc_i     (1'b0),
    .dec_i     (state_q == STOP || state_q == RELEASE),
    .count_o   (timer),
    .at_limit_o(timer_zero)
  );

  sat_counter #(.WIDTH(WW), .MAX(WATCHDOG_CYCLES), .DOWN(1'b0)) u_wd (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (detection_valid),
    .load_i    (1'b0),
    .inc_i     (!detection_valid),
    .dec_i     (1'b0),
    .count_o   (wd),
    .at_limit_o(wd_at_limit)
  );

  assign zebra_crossing_stop = stop_q;
  assign stop_event          = event_q;
  assign fault               = fault_q;
  assign state_o             = state_q;

`ifdef CROSSING_STATS_EN
  logic [15:0] frames_q, stops_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_q <= '0;
      stops_q  <= '0;
    end else begin
      if (detection_valid && frames_q != 16'hFFFF) frames_q <= frames_q + 16'd1;
      if (event_d && stops_q != 16'hFFFF)          stops_q  <= stops_q + 16'd1;
    end
  end

  assign frames_seen = frames_q;
  assign stop_count  = stops_q;
`endif

endmodule

// File: tb/tb_crossing_stop_fsm.sv
module tb_crossing_stop_fsm;

  localparam int CF   = 3;
  localparam int RF   = 2;
  localparam int MINB = 4;
  localparam int HOLD = 20;
  localparam int WD   = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dv = 1'b0;
  logic       cd = 1'b0;
  logic [7:0] bc = 8'd0;
  logic       stop, ev, flt;
  logic [2:0] st;
`ifdef CROSSING_STATS_EN
  logic [15:0] frames_seen, stop_count;
`endif

  int vectors = 0;
  int misses  = 0;
  int npulses = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  crossing_stop_fsm #(
    .CONFIRM_FRAMES(CF), .RELEASE_FRAMES(RF), .MIN_BLOBS(MINB),
    .HOLD_CYCLES(HOLD), .WATCHDOG_CYCLES(WD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .detection_valid(dv), .crossing_detected(cd),
    .blob_count(bc), .zebra_crossing_stop(stop), .stop_event(ev),
    .fault(flt), .state_o(st)
`ifdef CROSSING_STATS_EN
    , .frames_seen(frames_seen), .stop_count(stop_count)
`endif
  );

  // Behavioural model: mode number (0 idle .. 4 fault), hit streak,
  // release-miss count, cycle of last hold (re)start, clocks since last verdict.
  typedef struct {
    int mode;
    int streak;
    int rel;
    int load_cyc;
    int idle;
    int cyc;
    int ev;
    int frames;
    int stops;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.mode = 0; r.streak = 0; r.rel = 0; r.load_cyc = 0; r.idle = 0;
    r.cyc = 0; r.ev = 0; r.frames = 0; r.stops = 0;
    return r;
  endfunction

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  function automatic model_t step(input model_t p, input logic v, input logic c,
                                  input logic [7:0] b);
    model_t n;
    bit h;
    n = p;
    n.cyc = p.cyc + 1;
    n.ev  = 0;
    if (v) begin
      n.idle   = 0;
      n.frames = sat16(p.frames + 1);
      if (p.mode == 4) begin
        n.mode = 0; n.streak = 0; n.rel = 0;
      end else begin
        h = c && (int'(b) >= MINB);
        case (p.mode)
          0, 1: begin
            if (h) begin
              n.streak = p.streak + 1;
              if (n.streak >= CF) begin
                n.mode = 2; n.ev = 1; n.load_cyc = n.cyc; n.streak = 0;
                n.stops = sat16(p.stops + 1);
              end else n.mode = 1;
            end else begin
              n.mode = 0; n.streak = 0;
            end
          end
          2: begin
            if (h) n.load_cyc = n.cyc;
            else if (n.cyc - p.load_cyc >= HOLD) begin
              if (RF == 1) n.mode = 0;
              else begin n.mode = 3; n.rel = 1; end
            end
          end
          3: begin
            if (h) begin
              n.mode = 2; n.load_cyc = n.cyc; n.rel = 0;
            end else begin
              n.rel = p.rel + 1;
              if (n.rel >= RF) begin n.mode = 0; n.rel = 0; end
            end
          end
          default: n.mode = 0;
        endcase
      end
    end else begin
      if (p.idle < WD) n.idle = p.idle + 1;
      if (n.idle >= WD) begin n.mode = 4; n.streak = 0; n.rel = 0; end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else        m <= step(m, dv, cd, bc);
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      misses++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_stop",  int'(stop), (m.mode >= 2) ? 1 : 0);
      check("cyc_fault", int'(flt),  (m.mode == 4) ? 1 : 0);
      check("cyc_event", int'(ev),   m.ev);
      check("cyc_state", int'(st),   m.mode);
`ifdef CROSSING_STATS_EN
      check("cyc_frames", int'(frames_seen), m.frames);
      check("cyc_stops",  int'(stop_count),  m.stops);
`endif
    end
  end

  // Called at posedge+2; dv is sampled by the next edge, outputs are
  // examined at that edge +2.
  task automatic pulse(input logic c, input logic [7:0] b);
    dv = 1'b1; cd = c; bc = b;
    @(posedge clk);
    #2;
    dv = 1'b0; cd = 1'b0; bc = 8'd0;
    npulses++;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic expect_out(input string tag, input int s, input int f, input int e,
                            input int state);
    check({tag, "_stop"},  int'(stop), s);
    check({tag, "_fault"}, int'(flt),  f);
    check({tag, "_event"}, int'(ev),   e);
    check({tag, "_state"}, int'(st),   state);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    expect_out("reset", 0, 0, 0, 0);

    // confirm: three hits
    pulse(1, 8'd6); idle(9);
    pulse(1, 8'd6); expect_out("s1_h2", 0, 0, 0, 1); idle(9);
    pulse(1, 8'd6); expect_out("s1_h3", 1, 0, 1, 2);
`ifdef CROSSING_STATS_EN
    check("s1_stop_count", int'(stop_count), 1);
    check("s1_frames", int'(frames_seen), npulses);
`endif
    idle(1); expect_out("s1_evdrop", 1, 0, 0, 2); idle(8);

    // hold: miss at +10 ignored, miss at +20 (timer reaching 0) releases
    pulse(0, 8'd9); expect_out("s4_held", 1, 0, 0, 2); idle(9);
    pulse(0, 8'd9); expect_out("s4_rel1", 1, 0, 0, 3); idle(9);
    pulse(0, 8'd9); expect_out("s4_idle", 0, 0, 0, 0); idle(9);

    // back to STOP, release, then a hit in RELEASE
    repeat (3) begin pulse(1, 8'd7); idle(9); end
    pulse(0, 8'd0); idle(9);
    pulse(0, 8'd0); expect_out("s4_rel", 1, 0, 0, 3); idle(9);
    pulse(1, 8'd5); expect_out("s4_rehit", 1, 0, 0, 2);

    // asynchronous reset while in STOP
    rst_n = 1'b0;
    #1;
    expect_out("s6_rst", 0, 0, 0, 0);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    npulses = 0;
    idle(3); expect_out("s6_recover", 0, 0, 0, 0); idle(6);

    // hit, hit, miss, hit, hit
    pulse(1, 8'd6); idle(9);
    pulse(1, 8'd6); idle(9);
    pulse(0, 8'd9); expect_out("s2_miss", 0, 0, 0, 0); idle(9);
    pulse(1, 8'd6); idle(9);
    pulse(1, 8'd6); expect_out("s2_cnt2", 0, 0, 0, 1); idle(9);

    // blob_count threshold
    pulse(1, 8'd3); expect_out("s3_b3a", 0, 0, 0, 0); idle(9);
    pulse(1, 8'd3); expect_out("s3_b3b", 0, 0, 0, 0); idle(9);
    pulse(1, 8'd4); expect_out("s3_b4", 0, 0, 0, 1); idle(9);
    pulse(0, 8'd200); expect_out("s3_nocross", 0, 0, 0, 0); idle(9);

    // verdict exactly 100 clocks after the previous one beats the watchdog
    idle(90);
    pulse(1, 8'd6); expect_out("wd_race", 0, 0, 0, 1);

    // watchdog expiry
    idle(99); expect_out("s5_pre", 0, 0, 0, 1);
    idle(1);  expect_out("s5_fault", 1, 1, 0, 4);
    idle(20); expect_out("s5_hold", 1, 1, 0, 4);
    pulse(1, 8'd6); expect_out("s5_exit", 0, 0, 0, 0); idle(9);
    pulse(1, 8'd6); expect_out("s5_after", 0, 0, 0, 1);
`ifdef CROSSING_STATS_EN
    check("s5_frames", int'(frames_seen), npulses);
`endif
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
